grf_wb_arbiter: RTL

//   Sole write initiator for the GRF write port (reg_write/reg_addr/reg_data/pc).

---
 rtl/grf_wb_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: merges W-stage writes and queued multiply/divide results onto the GRF write port.
module grf_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic [31:0] pipe_pc,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    input  logic [31:0] md_pc,
    output logic        reg_write,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_data,
    output logic [31:0] pc,
    output logic [31:0] pending
);
    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [31:0]      q_pc   [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [AW-1:0]    head, tail;
    logic [AW:0]      count;
    logic             pipe_req, store, pop;

    assign pipe_req = pipe_we && pipe_addr != 5'd0;
    assign md_ready = count != (AW+1)'(DEPTH);
    assign store    = md_valid && md_ready && md_addr != 5'd0;
    assign pop      = !pipe_req && count != '0;

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (q_valid[i]) pending[q_addr[i]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (store) begin
            q_addr[tail] <= md_addr;
            q_data[tail] <= md_data;
            q_pc[tail]   <= md_pc;
        end
    end

    // Squash first so an entry enqueued this cycle still sees the younger pipe write.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid   <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            reg_write <= 1'b0;
            reg_addr  <= '0;
            reg_data  <= '0;
            pc        <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (pipe_req && q_addr[i] == pipe_addr) q_valid[i] <= 1'b0;
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (store) begin
                q_valid[tail] <= !(pipe_req && md_addr == pipe_addr);
                tail          <= tail + 1'b1;
            end
            count <= count + (AW+1)'(store) - (AW+1)'(pop);
            if (pipe_req) begin
                reg_write <= 1'b1;
                reg_addr  <= pipe_addr;
                reg_data  <= pipe_data;
                pc        <= pipe_pc;
            end else if (pop) begin
                reg_write <= q_valid[head];
                reg_addr  <= q_addr[head];
                reg_data  <= q_data[head];
                pc        <= q_pc[head];
            end else begin
                reg_write <= 1'b0;
            end
        end
    end
endmodule
